mips_fetch: RTL and testbench
=============================

Name: mips_fetch

Overview:
Instruction fetch stage sitting directly upstream of mips_decode. It owns the PC, requests instruction words from instruction memory, and buffers fetched {pc, inst} pairs in a small queue. It presents those pairs to decode with a valid/ready handshake. It consumes decode's control_type for the instruction being accepted and redirects the fetch stream to the branch, jump or jr target, flushing wrong-path words.

Parameters:
RESET_PC, 32'h0040_0000, PC of the first fetch after reset
QUEUE_DEPTH, 2, number of buffered {pc, inst} entries; legal values 1..4

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
imem_req  output  1  fetch request valid
imem_addr  output  32  word address of the request; always equals fetch_pc
imem_ack  input  1  memory returns imem_rdata this cycle; only meaningful while imem_req=1
imem_rdata  input  32  instruction word, valid when imem_req&imem_ack
inst_valid  output  1  queue head is valid
inst  output  32  queue-head instruction, feeds opcode/funct/imm of decode
inst_pc  output  32  PC of the queue-head instruction
inst_ready  input  1  decode/execute accepts the head this cycle
control_type  input  2  from decode for the head instruction: 00 fall-through, 01 branch taken, 10 j, 11 jr
jr_target  input  32  rs register value, used when control_type=11
fetch_fault  output  1  misaligned redirect trap (MISALIGN_TRAP_EN only; tied 0 otherwise)

Behaviour:
- Reset (synchronous, active-high): fetch_pc=RESET_PC, queue empty (count=0), fetch_fault=0. During and after the reset cycle: imem_req=0, inst_valid=0, inst/inst_pc=0.
- First imem_req is asserted in the cycle after reset deasserts.
- imem_req = (count < QUEUE_DEPTH) & !fetch_fault. Built from registered state only, with no combinational path from inst_ready or control_type.
- Transfer: imem_req&imem_ack pushes {fetch_pc, imem_rdata} and sets fetch_pc <= fetch_pc+4. Memory latency is 0..N cycles. imem_addr stays stable until ack unless a redirect occurs.
- Accept: inst_valid&inst_ready pops the head. Only then is control_type sampled; it is ignored otherwise.
- Targets, with p4 = inst_pc+4:
  - 01: p4 + sign_extend(inst[15:0])<<2
  - 10: {p4[31:28], inst[25:0], 2'b00}
  - 11: jr_target
- Redirect = accept with control_type != 00. On a redirect cycle:
  - The queue is flushed (count=0).
  - Any word acked in the same cycle is discarded.
  - fetch_pc <= target, and the next request issues the following cycle.
  - Redirect has priority over push.
- Simultaneous push and pop with no redirect: count unchanged, FIFO order preserved.
- Full (count=QUEUE_DEPTH): imem_req drops. A pop that cycle re-enables imem_req the next cycle, so there is one bubble; this is acceptable.
- Empty: inst_valid=0. A pushed word appears at the head the following cycle; there is no bypass.
- Address arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0 silently.
- Reset mid-request or with a full queue returns everything to the reset state next cycle. An ack in the reset cycle is ignored.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a redirect target with [1:0] != 0 sets fetch_fault=1 (sticky until reset), flushes the queue and holds imem_req=0. fetch_pc captures the raw target for debug.
- Undefined: target[1:0] is forced to 2'b00, and fetch_fault is tied to 0.

Decomposition:
- Package mips_fetch_pkg holds:
  - CT_FALLTHRU=2'b00, CT_BRANCH=2'b01, CT_JUMP=2'b10, CT_JR=2'b11
  - the default RESET_PC
  - a typedef for the 64-bit {pc, inst} queue entry
- Sub-module mips_fetch_queue: synchronous FIFO of entries with push, pop and flush inputs, flush having priority. It exposes count, full and empty. The top level holds the PC register, target computation and request logic.

Test Plan:
- Reset then imem_ack tied 1, inst_ready=1, control_type=00 -> imem_addr sequence 0x00400000, 0x00400004, 0x00400008; inst_pc follows one cycle later in the same order.
- inst_ready=0 with ack=1 -> exactly QUEUE_DEPTH (2) pushes, then imem_req=0; raising inst_ready drains 0x00400000 then 0x00400004 in order.
- Head at inst_pc=0x00400010, inst imm=16'hFFFE, control_type=01 accepted -> queue flushed, same-cycle acked word dropped, next imem_addr=0x0040000C.
- control_type=10 at inst_pc=0x00400020 with inst[25:0]=26'h0100008 -> next imem_addr=0x00400020; control_type=11 with jr_target=0x00400100 -> next imem_addr=0x00400100.
- imem_ack held 0 for 3 cycles -> imem_addr stable and imem_req high throughout; reset asserted mid-wait -> next cycle imem_req=0, inst_valid=0, fetch_pc=0x00400000.
- jr_target=0x00400102, control_type=11 -> with MISALIGN_TRAP_EN: fetch_fault=1 and imem_req stays 0; without: next imem_addr=0x00400100.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared control-type codes, reset PC, queue entry type and redirect target helper
package mips_fetch_pkg;
    localparam logic [1:0] CT_FALLTHRU = 2'b00;
    localparam logic [1:0] CT_BRANCH   = 2'b01;
    localparam logic [1:0] CT_JUMP     = 2'b10;
    localparam logic [1:0] CT_JR       = 2'b11;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
    function automatic logic [31:0] calc_target(input logic [1:0] ct, input logic [31:0] pc,
                                                input logic [31:0] ins, input logic [31:0] jr);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        return ct == CT_BRANCH ? p4 + {{14{ins[15]}}, ins[15:0], 2'b00} :
               ct == CT_JUMP   ? {p4[31:28], ins[25:0], 2'b00} :
               ct == CT_JR     ? jr : p4;
    endfunction
endpackage

// File: rtl/mips_fetch_queue.sv
// mips_fetch_queue: small synchronous FIFO of {pc, inst} entries; flush beats push and pop
module mips_fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_data,
    output fetch_entry_t rd_data,
    output logic [2:0]   count,
    output logic         full,
    output logic         empty
);
    localparam logic [1:0] LAST    = 2'(DEPTH - 1);
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);
    // storage is sized for the largest legal depth so 2-bit pointers index it cleanly
    fetch_entry_t mem_q [4];
    fetch_entry_t mem_d [4];
    logic [1:0] rd_q, rd_d, wr_q, wr_d;
    logic [2:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    assign full    = cnt_q == DEPTH_C;
    assign empty   = cnt_q == 3'd0;
    assign count   = cnt_q;
    assign rd_data = mem_q[rd_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = wr_data;
        rd_d  = flush ? 2'd0 : do_pop  ? (rd_q == LAST ? 2'd0 : rd_q + 2'd1) : rd_q;
        wr_d  = flush ? 2'd0 : do_push ? (wr_q == LAST ? 2'd0 : wr_q + 2'd1) : wr_q;
        cnt_d = flush ? 3'd0 : cnt_q + 3'(do_push) - 3'(do_pop);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q <= '{default: '0};
            rd_q  <= 2'd0;
            wr_q  <= 2'd0;
            cnt_q <= 3'd0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mips_fetch.sv
// mips_fetch: PC, imem requests, fetch queue and redirects; MISALIGN_TRAP_EN enables the misaligned-target trap
module mips_fetch
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic [1:0]  control_type,
    input  logic [31:0] jr_target,
    output logic        fetch_fault
);
    logic [31:0] fetch_pc_q, fetch_pc_d, tgt_raw, tgt;
    logic run_q, full, empty, accept, redirect, acked;
    logic [2:0] count;
    fetch_entry_t head;
    // run_q keeps requests off for the first cycle after reset
    assign imem_req   = run_q & ~full & ~fetch_fault;
    assign imem_addr  = fetch_pc_q;
    assign inst_valid = count != 3'd0;
    assign inst       = empty ? 32'd0 : head.inst;
    assign inst_pc    = empty ? 32'd0 : head.pc;
    assign accept     = inst_valid & inst_ready;
    assign redirect   = accept & (control_type != CT_FALLTHRU);
    assign acked      = imem_req & imem_ack;
    mips_fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clock  (clock),
        .reset  (reset),
        .push   (acked & ~redirect),
        .pop    (accept),
        .flush  (redirect),
        .wr_data({fetch_pc_q, imem_rdata}),
        .rd_data(head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );
`ifdef MISALIGN_TRAP_EN
    logic fault_q, fault_d;
    assign fetch_fault = fault_q;
    always_ff @(posedge clock) begin
        if (reset) fault_q <= 1'b0;
        else fault_q <= fault_d;
    end
`else
    assign fetch_fault = 1'b0;
`endif
    always_comb begin
        tgt_raw = calc_target(control_type, inst_pc, inst, jr_target);
`ifdef MISALIGN_TRAP_EN
        tgt     = tgt_raw;
        fault_d = fault_q | (redirect & (tgt_raw[1:0] != 2'b00));
`else
        tgt     = tgt_raw & ~32'd3;
`endif
        fetch_pc_d = redirect ? tgt : acked ? fetch_pc_q + 32'd4 : fetch_pc_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            run_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            run_q      <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mips_fetch.sv
// tb_mips_fetch: directed scenario tasks for mips_fetch; MISALIGN_TRAP_EN selects the trap expectations
module tb_mips_fetch;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic imem_req, imem_ack, inst_valid, inst_ready, fetch_fault;
    logic [31:0] imem_addr, imem_rdata, inst, inst_pc, jr_target;
    logic [1:0] control_type;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // instruction memory image: a beq at 0x400010, a j at 0x400020, distinct filler elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == 32'h0040_0010 ? 32'h1000_FFFE :
               a == 32'h0040_0020 ? 32'h0810_0008 : ~a;
    endfunction
    assign imem_rdata = mem_word(imem_addr);

    mips_fetch dut (
        .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_ready(inst_ready), .control_type(control_type),
        .jr_target(jr_target), .fetch_fault(fetch_fault)
    );

    task automatic apply_reset();
        reset = 1'b1; imem_ack = 1'b0; inst_ready = 1'b0; control_type = 2'b00; jr_target = 32'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ack = 1'b1; inst_ready = 1'b1; control_type = 2'b00; jr_target = 32'd0;
        repeat (2) @(negedge clock);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        checks++; if ({inst, inst_pc} !== 64'd0) begin errors++; $display("FAIL reset_head: got %h %h want 0 0", inst, inst_pc); end
        checks++; if (imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL reset_addr: got %h want 00400000", imem_addr); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_first_cycle_req: got %b want 0", imem_req); end
    endtask

    task automatic test_stream();
        apply_reset();
        imem_ack = 1'b1; inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (i < 3) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000 + 32'(4 * i)) begin
                    errors++; $display("FAIL stream_addr%0d: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, 32'h0040_0000 + 32'(4 * i));
                end
            end
            if (i > 0) begin
                checks++;
                if (inst_valid !== 1'b1 || inst_pc !== 32'h0040_0000 + 32'(4 * (i - 1)) || inst !== mem_word(32'h0040_0000 + 32'(4 * (i - 1)))) begin
                    errors++; $display("FAIL stream_head%0d: got v=%b pc=%h inst=%h want pc=%h", i, inst_valid, inst_pc, inst, 32'h0040_0000 + 32'(4 * (i - 1)));
                end
            end
        end
    endtask

    task automatic test_full();
        apply_reset();
        imem_ack = 1'b1; inst_ready = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004) begin errors++; $display("FAIL full_second_req: got req=%b addr=%h want 1 00400004", imem_req, imem_addr); end
        @(negedge clock);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req_drop: got %b want 0", imem_req); end
        @(negedge clock);
        checks++; if (imem_req !== 1'b0 || inst_pc !== 32'h0040_0000) begin errors++; $display("FAIL full_hold: got req=%b pc=%h want 0 00400000", imem_req, inst_pc); end
        inst_ready = 1'b1;
        @(negedge clock);
        checks++; if (inst_pc !== 32'h0040_0004 || inst_valid !== 1'b1) begin errors++; $display("FAIL full_drain: got v=%b pc=%h want 1 00400004", inst_valid, inst_pc); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0008) begin errors++; $display("FAIL full_resume: got req=%b addr=%h want 1 00400008", imem_req, imem_addr); end
    endtask

    task automatic test_branch();
        apply_reset();
        imem_ack = 1'b1; inst_ready = 1'b1;
        repeat (6) @(negedge clock);
        checks++; if (inst_pc !== 32'h0040_0010 || inst !== 32'h1000_FFFE) begin errors++; $display("FAIL branch_head: got pc=%h inst=%h want 00400010 1000fffe", inst_pc, inst); end
        control_type = 2'b01;
        @(negedge clock);
        control_type = 2'b00;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL branch_flush: got %b want 0", inst_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_000C) begin errors++; $display("FAIL branch_target: got req=%b addr=%h want 1 0040000c", imem_req, imem_addr); end
        @(negedge clock);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0040_000C) begin errors++; $display("FAIL branch_refill: got v=%b pc=%h want 1 0040000c", inst_valid, inst_pc); end
    endtask

    task automatic test_jump();
        apply_reset();
        imem_ack = 1'b1; inst_ready = 1'b1;
        repeat (10) @(negedge clock);
        checks++; if (inst_pc !== 32'h0040_0020 || inst !== 32'h0810_0008) begin errors++; $display("FAIL jump_head: got pc=%h inst=%h want 00400020 08100008", inst_pc, inst); end
        control_type = 2'b10;
        @(negedge clock);
        control_type = 2'b00;
        checks++; if (imem_addr !== 32'h0040_0020 || inst_valid !== 1'b0) begin errors++; $display("FAIL jump_target: got addr=%h v=%b want 00400020 0", imem_addr, inst_valid); end
        @(negedge clock);
        checks++; if (inst_pc !== 32'h0040_0020) begin errors++; $display("FAIL jr_head: got %h want 00400020", inst_pc); end
        control_type = 2'b11; jr_target = 32'h0040_0100;
        @(negedge clock);
        control_type = 2'b00;
        checks++; if (imem_addr !== 32'h0040_0100 || inst_valid !== 1'b0) begin errors++; $display("FAIL jr_target: got addr=%h v=%b want 00400100 0", imem_addr, inst_valid); end
    endtask

    task automatic test_wrap();
        apply_reset();
        imem_ack = 1'b1; inst_ready = 1'b1;
        repeat (2) @(negedge clock);
        control_type = 2'b11; jr_target = 32'hFFFF_FFFC;
        @(negedge clock);
        control_type = 2'b00;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target: got %h want fffffffc", imem_addr); end
        @(negedge clock);
        checks++; if (imem_addr !== 32'h0000_0000 || inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got addr=%h pc=%h want 00000000 fffffffc", imem_addr, inst_pc); end
    endtask

    task automatic test_stall();
        apply_reset();
        imem_ack = 1'b0; inst_ready = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000 || inst_valid !== 1'b0) begin
                errors++; $display("FAIL stall%0d: got req=%b addr=%h v=%b want 1 00400000 0", i, imem_req, imem_addr, inst_valid);
            end
        end
        reset = 1'b1; imem_ack = 1'b1;
        @(negedge clock);
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL stall_reset: got req=%b v=%b addr=%h want 0 0 00400000", imem_req, inst_valid, imem_addr); end
        reset = 1'b0;
        @(negedge clock);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_ack_ignored: got %b want 0", inst_valid); end
    endtask

    task automatic test_misalign();
        apply_reset();
        imem_ack = 1'b1; inst_ready = 1'b1;
        repeat (2) @(negedge clock);
        control_type = 2'b11; jr_target = 32'h0040_0102;
        @(negedge clock);
        control_type = 2'b00;
`ifdef MISALIGN_TRAP_EN
        checks++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL misalign_trap: got fault=%b req=%b want 1 0", fetch_fault, imem_req); end
        @(negedge clock);
        checks++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 32'h0040_0102) begin errors++; $display("FAIL misalign_sticky: got fault=%b req=%b v=%b addr=%h want 1 0 0 00400102", fetch_fault, imem_req, inst_valid, imem_addr); end
`else
        checks++; if (imem_addr !== 32'h0040_0100 || fetch_fault !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL misalign_align: got addr=%h fault=%b req=%b want 00400100 0 1", imem_addr, fetch_fault, imem_req); end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_branch();
        test_jump();
        test_wrap();
        test_stall();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
